mod3_serial_tx: RTL
===================

# mod3_serial_tx

Serial transmitter for the mod-3 checked bit stream. It accepts a W-bit parallel word through a valid/ready handshake and shifts it out MSB-first, one bit per clock. It then appends a 2-bit trailer chosen so that the full (W+2)-bit stream value is divisible by 3. The serial divisibility checker at the far end of the link therefore reports "divisible" on the final trailer bit of every error-free frame.

## Interface
- W, default 8: data word width in bits; legal range is W ≥ 2.
- clk  input  1: single clock; all state updates on the rising edge.
- reset  input  1: synchronous, active-high; sampled on the rising edge of clk.
- in_data  input  W: word to transmit; sampled only on the accept edge.
- in_valid  input  1: in_data is valid.
- in_ready  output  1: block can accept a word this cycle.
- tx_bit  output  1: serial data bit, MSB-first, then 2 trailer bits (MSB first).
- tx_valid  output  1: tx_bit carries a frame bit this cycle.
- tx_last  output  1: tx_bit is the final (second) trailer bit of the frame.

## Operation
- States:
  - IDLE: no frame in progress.
  - DATA: W cycles of data bits.
  - TRAIL: 2 cycles of trailer bits.
- Accept: a word is accepted on a rising edge where in_valid & in_ready = 1.
  - in_data is loaded into a W-bit shift register.
  - The bit counter and remainder are cleared.
  - State becomes DATA.
- in_ready is combinational: 1 in IDLE, and 1 in TRAIL on the cycle tx_last=1. It is 0 otherwise, and 0 while reset is high.
- DATA: tx_bit = shreg[W-1]. Each edge:
  - shreg shifts left by one.
  - The remainder updates r ← (2r + tx_bit) mod 3, with r encoded 2'd0/2'd1/2'd2. 2'd3 is unreachable; if it is ever reached, it is treated as 0 on the next update.
  - After the W-th data bit, state becomes TRAIL.
- Trailer value: t = (3 − r) mod 3, using r as it stands after all W data bits. This gives 0→00, 1→10, 2→01.
  - Reason: the stream value is V·4 + t, and 4 ≡ 1 (mod 3), so V·4 + t ≡ r + t ≡ 0.
- TRAIL: tx_bit = t[1] in the first cycle and t[0] in the second.
  - tx_last = 1 in the second cycle.
  - On that edge, state becomes IDLE, or DATA if a new word is accepted on that same edge.
- Words presented while in_ready = 0 are ignored; no buffering.
- reset = 1 takes priority over everything. On the edge it forces:
  - state IDLE
  - shreg 0
  - counter 0
  - r 0

## Timing
- Reset values of outputs: tx_bit = 0, tx_valid = 0, tx_last = 0, in_ready = 1 from the first cycle after reset deasserts.
- Latency: word accepted at edge k → MSB appears on tx_bit during cycle k+1, i.e. registered after edge k.
- A frame occupies exactly W+2 consecutive tx_valid cycles. tx_last is high only in cycle W+2.
- Back-to-back: if in_valid is held high, the next frame's MSB follows the previous tx_last cycle with zero gap. Throughput is one word per W+2 cycles.
- tx_bit = 0 whenever tx_valid = 0.
- Reset mid-frame: the frame is truncated with no trailer. tx_valid = 0 from the cycle after the reset edge. No partial-frame resume.
- in_valid asserted during reset: not accepted, since in_ready = 0.

## Structure
- Shared header mod3_defs.vh holds:
  - state encodings (IDLE/DATA/TRAIL)
  - remainder encodings (REM0/REM1/REM2)
  - the trailer mapping constants
- The checker and the bench include the same header.
- One sub-module: mod3_rem_tracker.
  - Ports: clk, reset, clr, en, bit, rem[1:0].
  - Implements the 3-state remainder recurrence.
  - Reused by the bench as a reference model.
- Top level holds: FSM, shift register, bit counter (ceil(log2(W+2)) bits), trailer mux.

## Test plan
- Reset, then word 8'h00 → bits 00000000 then trailer 00. tx_last on the 10th tx_valid cycle. Far-end checker reports divisible.
- Word 8'h05 (r=2) → data bits 00000101, trailer 01. Stream value 21; checker result 1 on tx_last.
- Word 8'h07 (r=1) → trailer 10, stream value 30. Word 8'hFF (r=0) → trailer 00, stream value 1020.
- in_valid held high with 8'h05 then 8'h07 → 20 consecutive tx_valid cycles, no gap. in_ready pulses only on the tx_last cycles; trailers 01 then 10.
- Reset asserted in the 4th data cycle of 8'hFF → next cycle tx_valid = 0 and in_ready = 1. A following 8'h07 frame still produces trailer 10, confirming the remainder was cleared.
- in_data changed and in_valid toggled mid-frame → transmitted bits unaffected and no extra accept. Random sweep of 1000 words at W=8 and W=5 → every frame passes the checker.

Source files
------------

// File: rtl/mod3_serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// mod3_serial_tx_pkg
// Shared definitions for the mod-3 checked serial transmitter:
//   - FSM state encodings (IDLE / DATA / TRAIL)
//   - remainder encodings (REM0 / REM1 / REM2)
//   - trailer mapping constants and the remainder-to-trailer helper
// No ports (package).
// ---------------------------------------------------------------------------
package mod3_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TRAIL = 2'd2
    } state_e;

    localparam logic [1:0] REM0 = 2'd0;
    localparam logic [1:0] REM1 = 2'd1;
    localparam logic [1:0] REM2 = 2'd2;

    // Trailer t = (3 - r) mod 3, sent MSB first.
    localparam logic [1:0] TRAIL_R0 = 2'b00;
    localparam logic [1:0] TRAIL_R1 = 2'b10;
    localparam logic [1:0] TRAIL_R2 = 2'b01;

    // The unreachable code 2'd3 maps like REM0 so the frame still closes cleanly.
    function automatic logic [1:0] trailer_of(input logic [1:0] rem);
        case (rem)
            REM1:    return TRAIL_R1;
            REM2:    return TRAIL_R2;
            default: return TRAIL_R0;
        endcase
    endfunction

endpackage

// File: rtl/mod3_serial_tx_rem_tracker.sv
// ---------------------------------------------------------------------------
// mod3_rem_tracker
// Tracks the running value of an MSB-first bit stream modulo 3 using the
// recurrence r <- (2r + bit) mod 3.
// Ports:
//   clk     in  1  rising-edge clock
//   reset   in  1  synchronous active-high reset (r -> 0)
//   clr     in  1  clear remainder to 0 on this edge (start of a new stream)
//   en      in  1  fold in_bit into the remainder on this edge
//   in_bit  in  1  next stream bit
//   rem     out 2  current remainder (0/1/2)
// ---------------------------------------------------------------------------
module mod3_rem_tracker
    import mod3_serial_tx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       in_bit,
    output logic [1:0] rem
);

    logic [1:0] rem_q;
    logic [1:0] rem_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rem_d = rem_q;
        if (clr) begin
            rem_d = REM0;
        end else if (en) begin
            case (rem_q)
                REM1:    rem_d = in_bit ? REM0 : REM2;   // 2+b : 2 or 3->0
                REM2:    rem_d = in_bit ? REM2 : REM1;   // 4+b : 1 or 2
                default: rem_d = in_bit ? REM1 : REM0;   // REM0, and 3 treated as 0
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) rem_q <= REM0;
        else       rem_q <= rem_d;
    end

    assign rem = rem_q;

endmodule

// File: rtl/mod3_serial_tx.sv
// ---------------------------------------------------------------------------
// mod3_serial_tx
// Accepts a W-bit word over valid/ready, shifts it out MSB-first one bit per
// clock, then appends a 2-bit trailer making the (W+2)-bit frame value a
// multiple of 3.
// Ports:
//   clk       in  1  rising-edge clock
//   reset     in  1  synchronous active-high reset
//   in_data   in  W  word to send, sampled on the accept edge
//   in_valid  in  1  in_data is valid
//   in_ready  out 1  word can be accepted this cycle (combinational)
//   tx_bit    out 1  serial bit (0 when tx_valid = 0)
//   tx_valid  out 1  tx_bit is a frame bit
//   tx_last   out 1  tx_bit is the second trailer bit
// ---------------------------------------------------------------------------
module mod3_serial_tx
    import mod3_serial_tx_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         tx_bit,
    output logic         tx_valid,
    output logic         tx_last
);

    localparam int CW = $clog2(W + 2);
    // Counter runs 0..W-1 through the data bits, then W, W+1 for the trailer.
    localparam logic [CW-1:0] CNT_LAST_DATA = CW'(W - 1);
    localparam logic [CW-1:0] CNT_TRAIL_END = CW'(W + 1);

    state_e        state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [1:0]    rem;
    logic [1:0]    trail;
    logic          accept;

    // Ready in IDLE and on the final trailer cycle, which gives zero-gap back-to-back frames.
    assign in_ready = !reset &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_TRAIL) && (cnt_q == CNT_TRAIL_END)));
    assign accept   = in_valid && in_ready;
    assign trail    = trailer_of(rem);

    mod3_rem_tracker u_rem (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (state_q == ST_DATA),
        .in_bit (shreg_q[W-1]),
        .rem    (rem)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        tx_bit   = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_DATA: begin
                tx_valid = 1'b1;
                tx_bit   = shreg_q[W-1];
                shreg_d  = {shreg_q[W-2:0], 1'b0};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST_DATA) state_d = ST_TRAIL;
            end
            ST_TRAIL: begin
                tx_valid = 1'b1;
                if (cnt_q == CNT_TRAIL_END) begin
                    tx_bit  = trail[0];
                    tx_last = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tx_bit  = trail[1];
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new word overrides the end-of-frame return to IDLE.
        if (accept) begin
            shreg_d = in_data;
            cnt_d   = '0;
            state_d = ST_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
